// File: rtl/cpu_defs.sv
// Shared definitions for the SIMPLE RISC controller: state codes, opcode/ALU
// constants and writeback-select encodings.
package cpu_defs;

   localparam int unsigned StateMinW = 5;

   typedef enum logic [StateMinW-1:0] {
      StRst,
      StIf1,
      StIf2,
      StUpc,
      StDec,
      StMovi,
      StGetA,
      StGetB,
      StComp,
      StWr,
      StAddr,
      StMrd1,
      StMrd2,
      StWrm,
      StGetBs,
      StStw,
      StHalt
   } state_e;

   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_LDR  = 3'b011;
   localparam logic [2:0] OP_STR  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [3:0] VSEL_NONE  = 4'b0000;
   localparam logic [3:0] VSEL_C     = 4'b0001;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_IMM8  = 4'b0100;
   localparam logic [3:0] VSEL_MDATA = 4'b1000;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into its fields and
// sign-extended immediates.
module instr_decoder (
   input  logic [15:0] ir_i,
   output logic [2:0]  opcode_o,
   output logic [1:0]  op_o,
   output logic [2:0]  rn_o,
   output logic [2:0]  rd_o,
   output logic [1:0]  sh_o,
   output logic [2:0]  rm_o,
   output logic [15:0] sximm5_o,
   output logic [15:0] sximm8_o
);

   assign opcode_o = ir_i[15:13];
   assign op_o     = ir_i[12:11];
   assign rn_o     = ir_i[10:8];
   assign rd_o     = ir_i[7:5];
   assign sh_o     = ir_i[4:3];
   assign rm_o     = ir_i[2:0];
   assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
   assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

endmodule

// File: rtl/control_fsm.sv
// Moore controller for the SIMPLE RISC datapath: fetch, decode and the
// per-opcode execute sequences, one instruction in flight.
module control_fsm
   import cpu_defs::*;
#(
   parameter int unsigned STATE_W = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] IRout,
   output logic        loadPC,
   output logic        loadIR,
   output logic        msel,
   output logic        mwrite,
   output logic        write,
   output logic [2:0]  writenum,
   output logic [2:0]  readnum,
   output logic [3:0]  vsel,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shiftinput,
   output logic [1:0]  ALUop,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8,
   output logic        halt
);

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;

   logic [STATE_W-1:0] state_q, state_d;
   state_e             state, next;

   instr_decoder u_dec (
      .ir_i     (IRout),
      .opcode_o (opcode),
      .op_o     (op),
      .rn_o     (rn),
      .rd_o     (rd),
      .sh_o     (sh),
      .rm_o     (rm),
      .sximm5_o (sximm5),
      .sximm8_o (sximm8)
   );

   assign state   = state_e'(state_q[StateMinW-1:0]);
   assign state_d = STATE_W'(next);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STATE_W'(StRst);
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         StRst:  next = StIf1;
         StIf1:  next = StIf2;
         StIf2:  next = StUpc;
         StUpc:  next = StDec;
         StDec: begin
            if (opcode == OP_MOV && op == 2'b10) begin
               next = StMovi;
            end else if (opcode == OP_MOV && op == 2'b00) begin
               next = StGetB;
            end else if (opcode == OP_ALU) begin
               next = (op == ALU_MVN) ? StGetB : StGetA;
            end else if ((opcode == OP_LDR || opcode == OP_STR) && op == 2'b00) begin
               next = StGetA;
            end else begin
               // OP_HALT and every undefined {opcode,op} land here
               next = StHalt;
            end
         end
         StMovi:  next = StIf1;
         StGetA:  next = (opcode == OP_ALU) ? StGetB : StAddr;
         StGetB:  next = StComp;
         StComp:  next = (opcode == OP_ALU && op == ALU_CMP) ? StIf1 : StWr;
         StWr:    next = StIf1;
         StAddr:  next = (opcode == OP_LDR) ? StMrd1 : StGetBs;
         StMrd1:  next = StMrd2;
         StMrd2:  next = StWrm;
         StWrm:   next = StIf1;
         StGetBs: next = StStw;
         StStw:   next = StIf1;
         StHalt:  next = StHalt;
         default: next = StRst;
      endcase
   end

   always_comb begin
      loadPC     = 1'b0;
      loadIR     = 1'b0;
      msel       = 1'b0;
      mwrite     = 1'b0;
      write      = 1'b0;
      writenum   = 3'b000;
      readnum    = 3'b000;
      vsel       = VSEL_NONE;
      asel       = 1'b0;
      bsel       = 1'b0;
      shiftinput = 2'b00;
      ALUop      = ALU_ADD;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      halt       = 1'b0;
      unique case (state)
         StIf2: loadIR = 1'b1;
         StUpc: loadPC = 1'b1;
         StMovi: begin
            write    = 1'b1;
            writenum = rn;
            vsel     = VSEL_IMM8;
         end
         StGetA: begin
            readnum = rn;
            loada   = 1'b1;
         end
         StGetB: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         StComp: begin
            shiftinput = sh;
            loadc      = 1'b1;
            // MOV passes B through by adding it to a zeroed A; flags untouched
            if (opcode == OP_MOV) begin
               asel = 1'b1;
            end else begin
               ALUop = op;
               loads = 1'b1;
            end
         end
         StWr: begin
            write    = 1'b1;
            writenum = rd;
            vsel     = VSEL_C;
         end
         StAddr: begin
            bsel  = 1'b1;
            loadc = 1'b1;
         end
         StMrd1, StMrd2: msel = 1'b1;
         StWrm: begin
            msel     = 1'b1;
            write    = 1'b1;
            writenum = rd;
            vsel     = VSEL_MDATA;
         end
         StGetBs: begin
            readnum = rd;
            loadb   = 1'b1;
         end
         StStw: begin
            msel   = 1'b1;
            mwrite = 1'b1;
         end
         StHalt: halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Random-instruction bench for control_fsm: a schedule model built from the
// instruction rules is compared against the controller outputs every cycle.
module tb_control_fsm;

   typedef struct packed {
      logic       load_pc;
      logic       load_ir;
      logic       msel;
      logic       mwrite;
      logic       write;
      logic [2:0] writenum;
      logic [2:0] readnum;
      logic [3:0] vsel;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] alu;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       halt;
   } ctl_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] IRout = 16'h0000;
   logic        loadPC, loadIR, msel, mwrite, write;
   logic [2:0]  writenum, readnum;
   logic [3:0]  vsel;
   logic        asel, bsel;
   logic [1:0]  shiftinput, ALUop;
   logic        loada, loadb, loadc, loads;
   logic [15:0] sximm5, sximm8;
   logic        halt;
   ctl_t        act;

   int          vectors = 0;
   int          miscompares = 0;
   ctl_t        sched[$];
   logic [15:0] prog[$];
   bit          in_rst = 1'b1;

   control_fsm #(.STATE_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .IRout      (IRout),
      .loadPC     (loadPC),
      .loadIR     (loadIR),
      .msel       (msel),
      .mwrite     (mwrite),
      .write      (write),
      .writenum   (writenum),
      .readnum    (readnum),
      .vsel       (vsel),
      .asel       (asel),
      .bsel       (bsel),
      .shiftinput (shiftinput),
      .ALUop      (ALUop),
      .loada      (loada),
      .loadb      (loadb),
      .loadc      (loadc),
      .loads      (loads),
      .sximm5     (sximm5),
      .sximm8     (sximm8),
      .halt       (halt)
   );

   always #5 clk = ~clk;

   assign act = {loadPC, loadIR, msel, mwrite, write, writenum, readnum, vsel, asel, bsel,
                 shiftinput, ALUop, loada, loadb, loadc, loads, halt};

   // Execute steps after DEC for one instruction; returns the step count.
   function automatic int build(input logic [15:0] ir, output ctl_t s [6]);
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op, sh;
      ctl_t       c;
      bit         mov;
      int         n = 0;
      opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
      rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
      for (int i = 0; i < 6; i++) s[i] = '0;
      if (opc == 3'b110 && op == 2'b10) begin
         c = '0; c.write = 1'b1; c.writenum = rn; c.vsel = 4'b0100; s[n] = c; n++;
      end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
         mov = (opc == 3'b110);
         if (!mov && op != 2'b11) begin
            c = '0; c.readnum = rn; c.loada = 1'b1; s[n] = c; n++;
         end
         c = '0; c.readnum = rm; c.loadb = 1'b1; s[n] = c; n++;
         c = '0; c.asel = mov; c.alu = mov ? 2'b00 : op; c.shift = sh;
         c.loadc = 1'b1; c.loads = !mov; s[n] = c; n++;
         if (mov || op != 2'b01) begin
            c = '0; c.write = 1'b1; c.writenum = rd; c.vsel = 4'b0001; s[n] = c; n++;
         end
      end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
         c = '0; c.readnum = rn; c.loada = 1'b1; s[n] = c; n++;
         c = '0; c.bsel = 1'b1; c.loadc = 1'b1; s[n] = c; n++;
         if (opc == 3'b011) begin
            c = '0; c.msel = 1'b1; s[n] = c; n++;
            s[n] = c; n++;
            c.write = 1'b1; c.writenum = rd; c.vsel = 4'b1000; s[n] = c; n++;
         end else begin
            c = '0; c.readnum = rd; c.loadb = 1'b1; s[n] = c; n++;
            c = '0; c.msel = 1'b1; c.mwrite = 1'b1; s[n] = c; n++;
         end
      end else begin
         c = '0; c.halt = 1'b1; s[n] = c; n++;
      end
      return n;
   endfunction

   function automatic int lat_of(input logic [15:0] ir);
      case (ir[15:11])
         5'b11010: return 5;
         5'b11000: return 7;
         5'b10111, 5'b10101: return 7;
         5'b10100, 5'b10110: return 8;
         5'b01100: return 9;
         5'b10000: return 8;
         default:  return 0;
      endcase
   endfunction

   function automatic logic [15:0] next_instr();
      logic [15:0] r;
      int          k;
      if (prog.size() > 0) return prog.pop_front();
      r = 16'($urandom);
      k = int'($urandom_range(0, 4));
      case (k)
         0:       r[15:11] = 5'b11010;
         1:       r[15:11] = 5'b11000;
         2:       r[15:13] = 3'b101;
         3:       r[15:11] = 5'b01100;
         default: r[15:11] = 5'b10000;
      endcase
      return r;
   endfunction

   // Reference model: owns the expected-output schedule and the IR contents.
   initial begin : model
      ctl_t c;
      ctl_t s [6];
      int   n;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            sched.delete();
            in_rst = 1'b1;
         end else if (in_rst) begin
            in_rst = 1'b0;
            c = '0; sched.push_back(c);
            c.load_ir = 1'b1; sched.push_back(c);
         end else if (sched.size() > 0 && !(sched.size() == 1 && sched[0].halt)) begin
            c = sched.pop_front();
            if (c.load_ir) begin
               IRout = next_instr();
               c = '0; c.load_pc = 1'b1; sched.push_back(c);
               c = '0; sched.push_back(c);
               n = build(IRout, s);
               for (int i = 0; i < n; i++) sched.push_back(s[i]);
            end
            if (sched.size() == 0) begin
               c = '0; sched.push_back(c);
               c.load_ir = 1'b1; sched.push_back(c);
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   int gap = 0;
   bit have_prev = 1'b0;
   always @(negedge clk) begin : cmp
      ctl_t e;
      int   v;
      e = '0;
      if (!(reset || in_rst)) begin
         if (sched.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL sched_empty at %0t: got no expectation, want one", $time);
         end else begin
            e = sched[0];
         end
      end
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL ctl at %0t ir=%h: got %h want %h", $time, IRout, act, e);
      end
      v = int'(IRout[4:0]);
      if (v > 15) v -= 32;
      vectors++;
      if (sximm5 !== 16'(v)) begin
         miscompares++;
         $display("FAIL sximm5 ir=%h: got %h want %h", IRout, sximm5, 16'(v));
      end
      v = int'(IRout[7:0]);
      if (v > 127) v -= 256;
      vectors++;
      if (sximm8 !== 16'(v)) begin
         miscompares++;
         $display("FAIL sximm8 ir=%h: got %h want %h", IRout, sximm8, 16'(v));
      end
      if (reset) begin
         have_prev = 1'b0;
         gap = 0;
      end else begin
         gap++;
         if (loadIR === 1'b1) begin
            if (have_prev) begin
               vectors++;
               if (gap != lat_of(IRout)) begin
                  miscompares++;
                  $display("FAIL latency ir=%h: got %0d want %0d", IRout, gap, lat_of(IRout));
               end
            end
            have_prev = 1'b1;
            gap = 0;
         end
      end
   end

   task automatic pin(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL model_%s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic wait_until(input int which, input int budget, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(posedge clk);
         #2;
         case (which)
            0:       hit = (loads === 1'b1) && (IRout == 16'hA148);
            default: hit = (halt === 1'b1);
         endcase
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL wait_%s: got timeout after %0d cycles, want event", name, budget);
      end
   endtask

   task automatic pulse_reset(input int cycles);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin : stim
      ctl_t s [6];
      int   n;
      // Pin the model on the hand-decoded instructions.
      n = build(16'hD105, s);
      pin("movi_len", n, 1);
      pin("movi_wnum", int'(s[0].writenum), 1);
      pin("movi_vsel", int'(s[0].vsel), 4);
      n = build(16'hA148, s);
      pin("add_len", n, 4);
      pin("add_geta_rn", int'(s[0].readnum), 1);
      pin("add_getb_rm", int'(s[1].readnum), 0);
      pin("add_shift", int'(s[2].shift), 1);
      pin("add_wnum", int'(s[3].writenum), 2);
      n = build(16'hA900, s);
      pin("cmp_len", n, 3);
      pin("cmp_alu", int'(s[2].alu), 1);
      n = build(16'h617F, s);
      pin("ldr_len", n, 5);
      pin("ldr_vsel", int'(s[4].vsel), 8);
      pin("ldr_wnum", int'(s[4].writenum), 3);
      n = build(16'h8162, s);
      pin("str_len", n, 4);
      pin("str_getb_rd", int'(s[2].readnum), 3);
      pin("str_mwrite", int'(s[3].mwrite), 1);
      n = build(16'hC800, s);
      pin("undef_halt", int'(s[0].halt), 1);

      prog.push_back(16'hD105);
      prog.push_back(16'hA148);
      prog.push_back(16'hA900);
      prog.push_back(16'h617F);
      prog.push_back(16'h8162);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (60) @(posedge clk);

      // Abort an ADD in its COMP cycle.
      prog.push_back(16'hA148);
      wait_until(0, 60, "add_comp");
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      for (int r = 0; r < 5; r++) begin
         repeat ($urandom_range(30, 120)) @(posedge clk);
         pulse_reset(int'($urandom_range(1, 3)));
      end
      repeat (200) @(posedge clk);

      prog.push_back(16'hE000);
      wait_until(1, 60, "halt");
      repeat (20) @(posedge clk);
      pulse_reset(2);
      prog.push_back(16'hC800);
      wait_until(1, 60, "undef");
      repeat (20) @(posedge clk);
      pulse_reset(1);
      repeat (40) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Moore controller for the SIMPLE RISC machine; sits directly upstream of the datapath.
- Consumes the datapath's IRout.
- Drives every datapath control strobe, register select, immediate and memory-control input: fetch, decode, execute, writeback, load/store.
- One instruction in flight. Fetch/decode sequencing is fixed; execute sequence depends on opcode/op.

Parameters:
STATE_W, 5, width of the state register (min 5 to encode all states).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces state RST
IRout  in  16  instruction register contents from datapath
loadPC  out  1  PC load enable
loadIR  out  1  IR load enable
msel  out  1  memory address select: 0=PC, 1=C (datapath_out)
mwrite  out  1  memory write strobe; write data is datapath Bin
write  out  1  register file write enable
writenum  out  3  register file write index
readnum  out  3  register file read index
vsel  out  4  one-hot writeback select: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C
asel  out  1  1 selects 16'b0 as Ain
bsel  out  1  1 selects sximm5 as Bin
shiftinput  out  2  shifter op
ALUop  out  2  ALU op
loada, loadb, loadc, loads  out  1 each  A/B/C/status register enables
sximm5  out  16  sign-extended IRout[4:0]
sximm8  out  16  sign-extended IRout[7:0]
halt  out  1  high in HALT state

Behaviour:
Reset and outputs:
- Reset is asynchronous, active-high, on clk/reset.
- State register is async-cleared to RST. Outputs are pure functions of state and IRout (Moore).
- In RST: all strobes 0, vsel=0000, halt=0.
- Reset asserted mid-instruction aborts immediately with no partial write. First edge after release goes to IF1.

Combinational fields:
- Field decode always valid: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- sximm5 and sximm8 are combinational from IRout.
- Any output not named for a state is 0 in that state.

Fetch (every instruction):
- IF1: msel=0.
- IF2: msel=0, loadIR=1.
- UPC: loadPC=1.
- DEC: no strobes; branches on {opcode,op}.

Execute sequences (all end by returning to IF1):
- 110_10 MOV Rn,#im8: MOVI (write=1, writenum=Rn, vsel=0100).
- 110_00 MOV Rd,Rm{,sh}: GETB → COMP → WR.
  - COMP: asel=1, bsel=0, ALUop=00, shiftinput=sh, loadc=1.
- 101_xx ALU (ADD/CMP/AND/MVN): GETA → GETB → COMP → WR.
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - COMP: asel=0, bsel=0, ALUop=op, shiftinput=sh, loadc=1, loads=1.
  - WR: write=1, writenum=Rd, vsel=0001.
  - CMP (op=01) skips WR: COMP → IF1.
  - MVN: GETA is skipped (GETB → COMP).
- 011_00 LDR Rd,[Rn,#im5]: GETA → ADDR → MRD1 → MRD2 → WRM.
  - ADDR: asel=0, bsel=1, ALUop=00, loadc=1.
  - MRD1, MRD2: msel=1 (synchronous RAM, 1-cycle read).
  - WRM: msel=1, write=1, writenum=Rd, vsel=1000.
- 100_00 STR Rd,[Rn,#im5]: GETA → ADDR → GETB' → STW.
  - GETB': readnum=Rd, loadb=1.
  - STW: msel=1, mwrite=1, bsel=0, shiftinput=00.
- 111_xx HALT, and every undefined {opcode,op}: HALT.
  - halt=1, all strobes 0.
  - Self-loop until reset.

Latency (IF1 entry to next IF1 entry, cycles):
- MOVI 5; MOV 7; MVN 7; CMP 7; ADD/AND 8; LDR 9; STR 8.

Invariants:
- IRout is stable outside IF2; the controller never depends on IRout changing mid-instruction.
- mwrite and write are never both 1.
- vsel is one-hot whenever write=1, else 0000.

Decomposition:
- Shared package (cpu_defs):
  - state encodings.
  - opcode/op constants (OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_HALT=111).
  - ALUop constants (ADD=00, CMP=01, AND=10, MVN=11).
  - vsel one-hot constants.
- Sub-module instr_decoder (combinational): IRout → opcode, op, Rn, Rd, Rm, sh, sximm5, sximm8.
- control_fsm holds the state register, next-state logic and output decode.

Test Plan:
1. reset=1 asserted during COMP of ADD → same cycle: all strobes 0, halt=0; release → IF1 on next edge; no write pulse seen.
2. IRout=16'hD105 (MOV R1,#5) → MOVI cycle: write=1, writenum=001, vsel=0100, sximm8=16'h0005; 5 cycles between IF1 entries.
3. IRout=16'hA148 (ADD R2,R1,R0,LSL#1) →
   - GETA: readnum=001, loada=1.
   - GETB: readnum=000, loadb=1.
   - COMP: ALUop=00, shiftinput=01, loadc=1, loads=1.
   - WR: writenum=010, vsel=0001.
   - 8 cycles total.
4. IRout=16'hA900 (CMP R1,R0) → COMP: ALUop=01, loads=1; no write cycle; IF1 follows COMP; 7 cycles.
5. IRout=16'h617F (LDR R3,[R1,#-1]) →
   - sximm5=16'hFFFF.
   - ADDR: bsel=1, loadc=1.
   - MRD1/MRD2: msel=1.
   - WRM: write=1, writenum=011, vsel=1000.
   IRout=16'h8162 (STR R3,[R1,#2]) →
   - GETB': readnum=011.
   - STW: exactly one cycle mwrite=1, msel=1.
6. IRout=16'hE000 (HALT) and IRout=16'hC800 (undefined) → halt=1 held, no strobes for 20 cycles; reset pulse → IF1.
